// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-requester arbiter for the single data-memory port, with
//            round-robin or fixed priority, burst locking and a hold limit.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int PRIO_MODE = 0,
    parameter int MAX_HOLD  = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,

    input  logic          i_req0,
    input  logic          i_we0,
    input  logic          i_lock0,
    input  logic [AW-1:0] i_addr0,
    input  logic [DW-1:0] i_wdata0,
    output logic          o_gnt0,
    output logic          o_rvalid0,
    output logic [DW-1:0] o_rdata0,

    input  logic          i_req1,
    input  logic          i_we1,
    input  logic          i_lock1,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_gnt1,
    output logic          o_rvalid1,
    output logic [DW-1:0] o_rdata1,

    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,

    output logic [1:0]    o_owner
);

    localparam logic [7:0] C_MAX_HOLD = 8'(MAX_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    state_t        r_state;
    logic          r_last_served;
    logic [7:0]    r_hold_cnt;
    logic          r_rd_pending0;
    logic          r_rd_pending1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_any_gnt;
    logic          w_lock;
    logic          w_other_req;
    logic [7:0]    w_hold_inc;
    logic          w_force_release;

    // Grants are suppressed during reset so no beat (and no write) can slip
    // through in the reset cycle.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!i_reset) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req0 && i_req1) begin
                        if ((PRIO_MODE == 1) || r_last_served) begin
                            w_gnt0 = 1'b1;
                        end else begin
                            w_gnt1 = 1'b1;
                        end
                    end else begin
                        w_gnt0 = i_req0;
                        w_gnt1 = i_req1;
                    end
                end
                ST_OWN0: w_gnt0 = i_req0;
                ST_OWN1: w_gnt1 = i_req1;
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

    assign w_any_gnt = w_gnt0 | w_gnt1;

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        w_lock      = 1'b0;
        if (w_gnt0) begin
            o_mem_we    = i_we0;
            o_mem_addr  = i_addr0;
            o_mem_wdata = i_wdata0;
            w_lock      = i_lock0;
        end else if (w_gnt1) begin
            o_mem_we    = i_we1;
            o_mem_addr  = i_addr1;
            o_mem_wdata = i_wdata1;
            w_lock      = i_lock1;
        end
    end

    // hold_cnt after this beat counts the beats of the burst so far; the
    // burst is cut once that count reaches MAX_HOLD with the other side waiting.
    assign w_other_req     = (r_state == ST_OWN0) ? i_req1 : i_req0;
    assign w_hold_inc      = (r_hold_cnt >= C_MAX_HOLD) ? C_MAX_HOLD : (r_hold_cnt + 8'd1);
    assign w_force_release = (w_hold_inc == C_MAX_HOLD) && w_other_req;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_last_served <= 1'b1;
            r_hold_cnt    <= '0;
            r_rd_pending0 <= 1'b0;
            r_rd_pending1 <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
        end else begin
            r_rd_pending0 <= w_gnt0 && !i_we0;
            r_rd_pending1 <= w_gnt1 && !i_we1;
            if (w_gnt0 && !i_we0) begin
                r_rdata0 <= i_mem_rdata;
            end
            if (w_gnt1 && !i_we1) begin
                r_rdata1 <= i_mem_rdata;
            end
            if (w_any_gnt) begin
                r_last_served <= w_gnt1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any_gnt && w_lock) begin
                        r_state    <= w_gnt0 ? ST_OWN0 : ST_OWN1;
                        r_hold_cnt <= 8'd1;
                    end
                end
                ST_OWN0: begin
                    if (!i_req0 || !i_lock0 || w_force_release) begin
                        r_state    <= ST_IDLE;
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= w_hold_inc;
                    end
                end
                ST_OWN1: begin
                    if (!i_req1 || !i_lock1 || w_force_release) begin
                        r_state    <= ST_IDLE;
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= w_hold_inc;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    assign o_gnt0    = w_gnt0;
    assign o_gnt1    = w_gnt1;
    assign o_rvalid0 = r_rd_pending0;
    assign o_rvalid1 = r_rd_pending1;
    assign o_rdata0  = r_rdata0;
    assign o_rdata1  = r_rdata1;
    assign o_owner   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench: round-robin and fixed-priority arbiters
//            driven in parallel and compared against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [31:0] a0, wd0, a1, wd1;

    logic [1:0]  d_gnt0, d_gnt1, d_rv0, d_rv1, d_we;
    logic [31:0] d_rd0 [2];
    logic [31:0] d_rd1 [2];
    logic [31:0] d_addr[2];
    logic [31:0] d_wd  [2];
    logic [31:0] d_mrd [2];
    logic [1:0]  d_own [2];

    logic [31:0] dmem[2][64];
    bit          mem_loaded;

    int checks = 0;
    int errors = 0;

    // Index 0: round-robin arbiter, index 1: fixed-priority arbiter.
    dmem_arbiter #(.AW(32), .DW(32), .PRIO_MODE(0), .MAX_HOLD(MAX_HOLD)) u_rr (
        .i_clk(clk), .i_reset(rst),
        .i_req0(req0), .i_we0(we0), .i_lock0(lock0), .i_addr0(a0), .i_wdata0(wd0),
        .o_gnt0(d_gnt0[0]), .o_rvalid0(d_rv0[0]), .o_rdata0(d_rd0[0]),
        .i_req1(req1), .i_we1(we1), .i_lock1(lock1), .i_addr1(a1), .i_wdata1(wd1),
        .o_gnt1(d_gnt1[0]), .o_rvalid1(d_rv1[0]), .o_rdata1(d_rd1[0]),
        .o_mem_we(d_we[0]), .o_mem_addr(d_addr[0]), .o_mem_wdata(d_wd[0]),
        .i_mem_rdata(d_mrd[0]), .o_owner(d_own[0])
    );

    dmem_arbiter #(.AW(32), .DW(32), .PRIO_MODE(1), .MAX_HOLD(MAX_HOLD)) u_fp (
        .i_clk(clk), .i_reset(rst),
        .i_req0(req0), .i_we0(we0), .i_lock0(lock0), .i_addr0(a0), .i_wdata0(wd0),
        .o_gnt0(d_gnt0[1]), .o_rvalid0(d_rv0[1]), .o_rdata0(d_rd0[1]),
        .i_req1(req1), .i_we1(we1), .i_lock1(lock1), .i_addr1(a1), .i_wdata1(wd1),
        .o_gnt1(d_gnt1[1]), .o_rvalid1(d_rv1[1]), .o_rdata1(d_rd1[1]),
        .o_mem_we(d_we[1]), .o_mem_addr(d_addr[1]), .o_mem_wdata(d_wd[1]),
        .i_mem_rdata(d_mrd[1]), .o_owner(d_own[1])
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    assign d_mrd[0] = dmem[0][d_addr[0][5:0]];
    assign d_mrd[1] = dmem[1][d_addr[1][5:0]];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int m = 0; m < 2; m++)
                for (int i = 0; i < 64; i++)
                    dmem[m][i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            for (int m = 0; m < 2; m++)
                if (d_we[m]) dmem[m][d_addr[m][5:0]] <= d_wd[m];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: owner 0 = free, 1 = port 0 owns, 2 = port 1 owns.
    // ------------------------------------------------------------------
    int          m_own [2];
    int          m_last[2];
    int          m_cnt [2];
    bit          m_rv0 [2];
    bit          m_rv1 [2];
    logic [31:0] m_rd0 [2];
    logic [31:0] m_rd1 [2];
    logic [31:0] mm[2][64];

    task automatic model_reset(input int m);
        m_own[m] = 0; m_last[m] = 1; m_cnt[m] = 0;
        m_rv0[m] = 0; m_rv1[m] = 0; m_rd0[m] = '0; m_rd1[m] = '0;
    endtask

    task automatic model_cycle(input int m);
        bit g0, g1, pwe, plk, oreq;
        logic [31:0] pa, pw;
        int x;
        g0 = 0; g1 = 0;
        if (!rst) begin
            if (m_own[m] == 1)       g0 = req0;
            else if (m_own[m] == 2)  g1 = req1;
            else if (req0 && req1) begin
                if (m == 1 || m_last[m] == 1) g0 = 1; else g1 = 1;
            end else begin
                g0 = req0; g1 = req1;
            end
        end
        pwe = g0 ? we0 : (g1 ? we1 : 1'b0);
        pa  = g0 ? a0  : (g1 ? a1  : 32'h0);
        pw  = g0 ? wd0 : (g1 ? wd1 : 32'h0);
        plk = g0 ? lock0 : lock1;

        chk($sformatf("gnt0[%0d]", m),     32'(d_gnt0[m]), 32'(g0));
        chk($sformatf("gnt1[%0d]", m),     32'(d_gnt1[m]), 32'(g1));
        chk($sformatf("mem_we[%0d]", m),   32'(d_we[m]),   32'(pwe));
        chk($sformatf("mem_addr[%0d]", m), d_addr[m],      pa);
        chk($sformatf("mem_wdata[%0d]", m),d_wd[m],        pw);
        chk($sformatf("rvalid0[%0d]", m),  32'(d_rv0[m]),  32'(m_rv0[m]));
        chk($sformatf("rvalid1[%0d]", m),  32'(d_rv1[m]),  32'(m_rv1[m]));
        chk($sformatf("rdata0[%0d]", m),   d_rd0[m],       m_rd0[m]);
        chk($sformatf("rdata1[%0d]", m),   d_rd1[m],       m_rd1[m]);
        chk($sformatf("owner[%0d]", m),    32'(d_own[m]),  32'(m_own[m]));

        if (rst) begin
            model_reset(m);
            return;
        end
        m_rv0[m] = g0 && !we0;
        m_rv1[m] = g1 && !we1;
        if (g0 && !we0) m_rd0[m] = mm[m][a0[5:0]];
        if (g1 && !we1) m_rd1[m] = mm[m][a1[5:0]];
        if (g0 && we0)  mm[m][a0[5:0]] = wd0;
        if (g1 && we1)  mm[m][a1[5:0]] = wd1;
        if (g0 || g1) begin
            x    = g0 ? 0 : 1;
            oreq = g0 ? req1 : req0;
            m_last[m] = x;
            if (m_own[m] == 0) begin
                if (plk) begin m_own[m] = x + 1; m_cnt[m] = 1; end
            end else begin
                m_cnt[m] = (m_cnt[m] < MAX_HOLD) ? m_cnt[m] + 1 : MAX_HOLD;
                if (!plk || (m_cnt[m] == MAX_HOLD && oreq)) m_own[m] = 0;
            end
        end else if (m_own[m] != 0) begin
            m_own[m] = 0;
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            model_reset(m);
            for (int i = 0; i < 64; i++) mm[m][i] = init_word(i);
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            model_cycle(0);
            model_cycle(1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req0 = 0; we0 = 0; lock0 = 0; a0 = '0; wd0 = '0;
        req1 = 0; we1 = 0; lock1 = 0; a1 = '0; wd1 = '0;
    endtask

    task automatic do_reset();
        rst = 1; idle_in(); tick(); rst = 0;
    endtask

    initial begin
        int n0, n1;
        rst = 1; idle_in();
        tick(); tick();
        rst = 0;

        // Single read from port 0 right after reset
        req0 = 1; we0 = 0; a0 = 32'h10;
        @(negedge clk);
        chk("t1_gnt0", 32'(d_gnt0[0]), 32'd1);
        chk("t1_we",   32'(d_we[0]),   32'd0);
        tick(); idle_in();
        @(negedge clk);
        chk("t1_rvalid0", 32'(d_rv0[0]), 32'd1);
        chk("t1_rdata0",  d_rd0[0],      32'hDEAD_BEEF);
        chk("t1_we_next", 32'(d_we[0]),  32'd0);
        tick();

        // Contending writes: alternation (RR) versus port 0 always (fixed)
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req0 = 1; we0 = 1; a0 = 32'h20 + 32'(i); wd0 = 32'hA0 + 32'(i);
            req1 = 1; we1 = 1; a1 = 32'h30 + 32'(i); wd1 = 32'hB0 + 32'(i);
            @(negedge clk);
            chk("t2_rr_gnt0", 32'(d_gnt0[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_rr_gnt1", 32'(d_gnt1[0]), (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("t2_rr_wdata", d_wd[0], (i % 2 == 1) ? 32'hB0 + 32'(i) : 32'hA0 + 32'(i));
            chk("t3_fp_gnt0", 32'(d_gnt0[1]), 32'd1);
            tick();
        end
        req0 = 0;
        @(negedge clk);
        chk("t3_fp_gnt1_after_drop", 32'(d_gnt1[1]), 32'd1);
        tick(); idle_in();

        // Port 1 locked burst cut at MAX_HOLD while port 0 waits
        do_reset();
        n0 = 0; n1 = 0;
        req1 = 1; lock1 = 1; we1 = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin req0 = 1; we0 = 0; a0 = 32'h5; end
            a1 = 32'h38 + 32'(i); wd1 = 32'hC000 + 32'(i);
            @(negedge clk);
            if (d_gnt1[0]) n0++;
            if (d_gnt1[1]) n1++;
            if (i >= 1) chk("t4_owner_locked", 32'(d_own[0]), 32'd2);
            tick();
        end
        @(negedge clk);
        chk("t4_rr_burst_len", 32'(n0), 32'd8);
        chk("t4_fp_burst_len", 32'(n1), 32'd8);
        chk("t4_rr_gnt0_after", 32'(d_gnt0[0]), 32'd1);
        chk("t4_rr_gnt1_after", 32'(d_gnt1[0]), 32'd0);
        chk("t4_owner_released", 32'(d_own[0]), 32'd0);
        chk("t4_fp_gnt0_after", 32'(d_gnt0[1]), 32'd1);
        tick(); idle_in();

        // Port 0 three-beat burst, last beat unlocked
        do_reset();
        req0 = 1; lock0 = 1; we0 = 1; a0 = 32'h1; wd0 = 32'h1111;
        req1 = 1; we1 = 0; a1 = 32'h2;
        @(negedge clk);
        chk("t5_beat1_gnt0", 32'(d_gnt0[0]), 32'd1);
        tick(); wd0 = 32'h2222;
        @(negedge clk);
        chk("t5_beat2_owner", 32'(d_own[0]), 32'd1);
        chk("t5_beat2_gnt1", 32'(d_gnt1[0]), 32'd0);
        tick(); lock0 = 0; wd0 = 32'h3333;
        @(negedge clk);
        chk("t5_beat3_owner", 32'(d_own[0]), 32'd1);
        chk("t5_beat3_gnt0", 32'(d_gnt0[0]), 32'd1);
        tick(); req0 = 0;
        @(negedge clk);
        chk("t5_after_gnt1",  32'(d_gnt1[0]), 32'd1);
        chk("t5_after_owner", 32'(d_own[0]),  32'd0);
        chk("t5_fp_after_gnt1", 32'(d_gnt1[1]), 32'd1);
        tick(); idle_in();

        // Reset in the middle of a port 0 locked read burst
        do_reset();
        req0 = 1; we0 = 0; lock0 = 1; a0 = 32'h7;
        tick(); a0 = 32'h8;
        @(negedge clk);
        chk("t6_owner_locked", 32'(d_own[0]), 32'd1);
        tick(); rst = 1; we0 = 1; wd0 = 32'h5A5A;
        @(negedge clk);
        chk("t6_rst_gnt0",    32'(d_gnt0[0]), 32'd0);
        chk("t6_rst_mem_we",  32'(d_we[0]),   32'd0);
        chk("t6_rst_rvalid0", 32'(d_rv0[0]),  32'd1);
        tick(); rst = 0; we0 = 0; lock0 = 0;
        @(negedge clk);
        chk("t6_post_rvalid0", 32'(d_rv0[0]),  32'd0);
        chk("t6_post_owner",   32'(d_own[0]),  32'd0);
        chk("t6_post_gnt0",    32'(d_gnt0[0]), 32'd1);
        tick(); idle_in();

        // Randomised traffic with persistent requests and occasional reset
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            req0  = req0 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
            req1  = req1 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
            lock0 = ($urandom_range(0, 19) < 17);
            lock1 = ($urandom_range(0, 19) < 17);
            we0   = $urandom_range(0, 1) == 1;
            we1   = $urandom_range(0, 1) == 1;
            a0    = $urandom; a1 = $urandom;
            wd0   = $urandom; wd1 = $urandom;
            tick();
        end
        rst = 0; idle_in();
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 (core load/store stage) and port 1 (debug/loader or DMA engine).
- Sits between the requesters and data_mem. It drives the memory's write enable, address and write data, and routes read data back to the requester that issued the read.
- Supports round-robin or fixed-priority arbitration.
- A requester may lock the port for a burst of consecutive beats. A hold limit bounds how long a lock can block the other requester.

Parameters:
- AW, 32, address width
- DW, 32, data width
- PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with port 0 always winning
- MAX_HOLD, 8, maximum accepted beats per lock while the other port is requesting; legal range 2..255

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous reset, active-high
- i_req0  in  1  port 0 requests a beat
- i_we0  in  1  port 0 beat is a write (1) or read (0)
- i_lock0  in  1  port 0 keeps ownership after this beat
- i_addr0  in  AW  port 0 address
- i_wdata0  in  DW  port 0 write data
- o_gnt0  out  1  port 0 beat accepted this cycle
- o_rvalid0  out  1  port 0 read data valid
- o_rdata0  out  DW  port 0 read data
- i_req1, i_we1, i_lock1, i_addr1, i_wdata1, o_gnt1, o_rvalid1, o_rdata1: same meaning as the port 0 signals, for port 1
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  AW  memory address
- o_mem_wdata  out  DW  memory write data
- i_mem_rdata  in  DW  memory read data; combinational from o_mem_addr
- o_owner  out  2  lock state: 00 = idle, 01 = port 0 locked, 10 = port 1 locked

Behaviour:
- State register: IDLE, OWN0, OWN1. Additional registers:
  - last_served: 1 bit
  - hold_cnt: 8 bits
  - rd_pending0, rd_pending1
  - read data registers
- Reset values:
  - state = IDLE; last_served = 1, so port 0 wins the first tie.
  - hold_cnt = 0; all o_gnt* = 0, o_rvalid* = 0, o_rdata* = 0.
  - o_mem_we = 0, o_mem_addr = 0, o_mem_wdata = 0; o_owner = 00.
- Grant rules:
  - Grants are combinational from the current state and the i_req* inputs.
  - o_gnt0 and o_gnt1 are one-hot or zero, never both.
  - A beat is accepted when gnt = 1; the requester must hold its request fields stable until granted.
- Arbitration in IDLE:
  - Only one request present: that port is granted.
  - Both requests present, PRIO_MODE = 1: port 0 is granted.
  - Both requests present, PRIO_MODE = 0: the port that is not last_served is granted.
  - last_served updates to the granted port on every accepted beat.
- Memory port:
  - The granted port's addr and wdata drive o_mem_addr and o_mem_wdata.
  - o_mem_we = granted port's we.
  - With no grant: o_mem_we = 0 and the address/data outputs are 0.
  - The arbiter never asserts o_mem_we without a grant.
- Read return:
  - On an accepted read, i_mem_rdata is registered into o_rdataX, and o_rvalidX = 1 on the next cycle for exactly one cycle.
  - Latency: grant in cycle N -> rvalid in cycle N+1.
  - o_rdataX holds its value until the next read return for that port.
  - Writes produce no rvalid.
- Locking (OWNx):
  - An accepted beat with lock = 1 moves the state from IDLE to OWNx and sets hold_cnt = 1.
  - In OWNx only port x can be granted; the other port waits, even under PRIO_MODE = 1.
  - Each accepted beat in OWNx increments hold_cnt.
  - The state returns to IDLE on the next edge when any of these holds:
    - (a) port x has a beat accepted with lock = 0. That beat completes normally.
    - (b) i_reqx = 0 in OWNx. No grant is given that cycle.
    - (c) Forced release: hold_cnt = MAX_HOLD on an accepted beat while the other port's req = 1. That beat completes, and last_served = x, so the other port wins next.
  - With the other port idle, the lock persists and hold_cnt saturates at MAX_HOLD.
- Simultaneous events:
  - A read returning to one port while the other port is granted is legal; rvalid and gnt are independent.
  - Back-to-back beats from the same port are allowed every cycle.
- Reset mid-burst: the lock is dropped, state = IDLE, and pending rvalids are cleared on the next edge. No memory write occurs in the reset cycle, because o_mem_we = 0 while i_reset = 1.

Test Plan:
- Reset, then req0 = 1 (read, addr 0x10, memory holds 0xDEADBEEF) -> o_gnt0 = 1 in the same cycle; next cycle o_rvalid0 = 1 and o_rdata0 = 0xDEADBEEF; o_mem_we = 0 throughout.
- PRIO_MODE = 0, both ports issue continuous write requests for 4 cycles -> grants alternate 0,1,0,1; o_mem_wdata follows the granted port each cycle; never two grants at once.
- PRIO_MODE = 1, both ports request for 3 cycles -> o_gnt0 = 1 all 3 cycles, o_gnt1 = 0; port 1 is granted in the cycle req0 drops.
- Port 1 locks with i_lock1 = 1 for 10 beats while req0 = 1, MAX_HOLD = 8 -> port 1 gets exactly 8 grants, port 0 is granted on the following cycle, and o_owner goes 10 -> 00.
- Port 0 locks and issues 3 beats, the third with lock = 0, while req1 = 1 throughout -> o_owner = 01 for beats 2-3; port 1 is granted on the cycle after beat 3.
- i_reset asserted during OWN0 with a read accepted the previous cycle -> next cycle o_rvalid0 = 0, o_owner = 00, o_mem_we = 0; the first request after reset deasserts is granted normally.
